// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg
// Shared types and defaults for the next-PC unit.
//   pc_state_t : sequencing state of the PC register (BOOT, RUN, PEND).
//   *_DEF      : default PC width, reset PC and sequential increment.
//   src_w()    : width of a redirect-source index for a given source count.
package pc_unit_pkg;

  localparam int PC_W_DEF     = 8;
  localparam int RESET_PC_DEF = 0;
  localparam int INC_DEF      = 1;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_t;

  // A single-source configuration still needs a 1-bit index field.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_next_unit_prio_enc.sv
// prio_enc
// Combinational priority encoder used to arbitrate live redirect requests.
// Ports:
//   req : request vector, bit 0 has the highest priority
//   any : at least one request bit is set
//   idx : index of the lowest set bit (0 when no bit is set)
module prio_enc
  import pc_unit_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = src_w(N)
) (
  input  logic [N-1:0]  req,
  output logic          any,
  output logic [IW-1:0] idx
);

  // Scanning from the top down lets the lowest set index overwrite the rest.
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit
// Registered program counter with prioritised redirects and stall handling.
// A redirect that arrives while stalled is held in a pending slot and applied
// when the stall releases, unless a strictly higher-priority live redirect
// arrives in the release cycle.
// Optional feature: define PC_MISALIGN_CHK_EN to add the misalign output and
// force the low ALIGN_BITS of every applied redirect target to zero.
// Ports:
//   clk            : system clock, rising edge
//   rst            : synchronous active-high reset
//   stall          : hold the PC this cycle
//   redirect_req   : per-source redirect request, index 0 highest priority
//   redirect_tgt   : flattened targets, source i at [i*PC_W +: PC_W]
//   pc             : current PC (registered)
//   pc_valid       : pc is a valid fetch address
//   redirect_taken : one-cycle pulse, pc was loaded from a redirect
//   taken_src      : source index of the last redirect taken (sticky)
//   pend           : a redirect is waiting for the stall to release
//   misalign       : (PC_MISALIGN_CHK_EN only) applied target had low bits set
module pc_next_unit
  import pc_unit_pkg::*;
#(
  parameter int PC_W       = PC_W_DEF,
  parameter int NUM_SRC    = 4,
  parameter int INC        = INC_DEF,
  parameter int RESET_PC   = RESET_PC_DEF,
  parameter int ALIGN_BITS = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic [NUM_SRC-1:0]        redirect_req,
  input  logic [NUM_SRC*PC_W-1:0]   redirect_tgt,
  output logic [PC_W-1:0]           pc,
  output logic                      pc_valid,
  output logic                      redirect_taken,
  output logic [src_w(NUM_SRC)-1:0] taken_src,
  output logic                      pend
`ifdef PC_MISALIGN_CHK_EN
  ,
  output logic                      misalign
`endif
);

  localparam int SW = src_w(NUM_SRC);

  pc_state_t       state;
  logic [PC_W-1:0] pend_tgt;
  logic [SW-1:0]   pend_src;

  logic            live_any;
  logic [SW-1:0]   live_idx;
  logic [PC_W-1:0] live_tgt;

  logic            use_live;
  logic [PC_W-1:0] sel_tgt;
  logic [SW-1:0]   sel_src;
  logic [PC_W-1:0] load_pc;

  prio_enc #(
    .N  (NUM_SRC),
    .IW (SW)
  ) u_prio_enc (
    .req (redirect_req),
    .any (live_any),
    .idx (live_idx)
  );

  assign live_tgt = redirect_tgt[int'(live_idx)*PC_W +: PC_W];

  // On stall release in PEND the live request only wins if it is strictly
  // higher priority than the pending one; in RUN the live winner is the only
  // candidate, so the same mux serves both states.
  always_comb begin
    use_live = 1'b1;
    if (state == PEND) use_live = live_any && (live_idx < pend_src);
    sel_tgt = use_live ? live_tgt : pend_tgt;
    sel_src = use_live ? live_idx : pend_src;
  end

`ifdef PC_MISALIGN_CHK_EN
  localparam logic [PC_W-1:0] ALIGN_MASK = (PC_W'(1) << ALIGN_BITS) - PC_W'(1);

  logic load_mis;

  // Low target bits are cleared on load and flagged if any were set.
  always_comb begin
    load_pc  = sel_tgt & ~ALIGN_MASK;
    load_mis = |(sel_tgt & ALIGN_MASK);
  end
`else
  assign load_pc = sel_tgt;
`endif

  // PC sequencing: BOOT presents RESET_PC once as the first fetch, RUN
  // advances or redirects, PEND holds a redirect captured during a stall.
  // Pulse outputs default low every cycle and are raised only on a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= BOOT;
      pc             <= PC_W'(RESET_PC);
      pc_valid       <= 1'b0;
      redirect_taken <= 1'b0;
      taken_src      <= '0;
      pend           <= 1'b0;
      pend_tgt       <= '0;
      pend_src       <= '0;
`ifdef PC_MISALIGN_CHK_EN
      misalign       <= 1'b0;
`endif
    end else begin
      redirect_taken <= 1'b0;
`ifdef PC_MISALIGN_CHK_EN
      misalign       <= 1'b0;
`endif
      case (state)
        BOOT: begin
          state    <= RUN;
          pc_valid <= 1'b1;
        end

        RUN: begin
          if (!stall) begin
            if (live_any) begin
              pc             <= load_pc;
              redirect_taken <= 1'b1;
              taken_src      <= sel_src;
`ifdef PC_MISALIGN_CHK_EN
              misalign       <= load_mis;
`endif
            end else begin
              pc <= pc + PC_W'(INC);
            end
          end else if (live_any) begin
            pend_tgt <= live_tgt;
            pend_src <= live_idx;
            pend     <= 1'b1;
            state    <= PEND;
          end
        end

        PEND: begin
          if (stall) begin
            // Equal priority replaces the entry so the newest target wins.
            if (live_any && (live_idx <= pend_src)) begin
              pend_tgt <= live_tgt;
              pend_src <= live_idx;
            end
          end else begin
            pc             <= load_pc;
            redirect_taken <= 1'b1;
            taken_src      <= sel_src;
`ifdef PC_MISALIGN_CHK_EN
            misalign       <= load_mis;
`endif
            pend           <= 1'b0;
            state          <= RUN;
          end
        end

        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit
// Directed scenarios plus a randomized run checked against a cycle model of
// the next-PC rules (PC_W=8, NUM_SRC=4, INC=1, RESET_PC=0x10, ALIGN_BITS=2).
module tb_pc_next_unit;

  localparam int PC_W  = 8;
  localparam int NSRC  = 4;
  localparam logic [7:0] RST_PC = 8'h10;
`ifdef PC_MISALIGN_CHK_EN
  localparam logic [7:0] MASK = 8'h03;
`else
  localparam logic [7:0] MASK = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [3:0]  redirect_req;
  logic [31:0] redirect_tgt;
  logic [7:0]  pc;
  logic        pc_valid;
  logic        redirect_taken;
  logic [1:0]  taken_src;
  logic        pend;
`ifdef PC_MISALIGN_CHK_EN
  logic        misalign;
`endif

  int passed = 0;
  int total  = 0;

  // Reference model state
  logic [7:0] m_pc;
  logic       m_valid, m_taken, m_pend, m_boot, m_mis;
  int         m_src, m_ptgt_src;
  logic [7:0] m_ptgt;

  pc_next_unit #(
    .PC_W       (PC_W),
    .NUM_SRC    (NSRC),
    .INC        (1),
    .RESET_PC   (16),
    .ALIGN_BITS (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_req   (redirect_req),
    .redirect_tgt   (redirect_tgt),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .redirect_taken (redirect_taken),
    .taken_src      (taken_src),
    .pend           (pend)
`ifdef PC_MISALIGN_CHK_EN
    ,
    .misalign       (misalign)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] tgt_of(input int i);
    return redirect_tgt[i*8 +: 8];
  endfunction

  // Apply a redirect target to the model.
  task automatic model_load(input logic [7:0] t, input int s);
    m_pc    = t & ~MASK;
    m_mis   = |(t & MASK);
    m_taken = 1'b1;
    m_src   = s;
  endtask

  // One clock edge of the model, evaluated from the inputs the DUT samples.
  task automatic model_step();
    int w;
    w = -1;
    for (int i = NSRC - 1; i >= 0; i--) if (redirect_req[i]) w = i;
    if (rst) begin
      m_pc = RST_PC; m_valid = 0; m_taken = 0; m_src = 0;
      m_pend = 0; m_boot = 1; m_mis = 0;
    end else if (m_boot) begin
      m_boot = 0; m_valid = 1; m_taken = 0; m_mis = 0;
    end else begin
      m_taken = 0; m_mis = 0;
      if (!m_pend) begin
        if (!stall) begin
          if (w >= 0) model_load(tgt_of(w), w);
          else m_pc = m_pc + 8'd1;
        end else if (w >= 0) begin
          m_pend = 1; m_ptgt = tgt_of(w); m_ptgt_src = w;
        end
      end else if (stall) begin
        if (w >= 0 && w <= m_ptgt_src) begin
          m_ptgt = tgt_of(w); m_ptgt_src = w;
        end
      end else begin
        if (w >= 0 && w < m_ptgt_src) model_load(tgt_of(w), w);
        else model_load(m_ptgt, m_ptgt_src);
        m_pend = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; redirect_req = '0;
  endtask

  task automatic test_reset();
    rst = 1; stall = 0; redirect_req = '0; redirect_tgt = '0;
    tick(); tick();
    total++; if (pc !== 8'h10) $display("[TB] FAIL reset_pc: got %h expected %h", pc, 8'h10); else passed++;
    total++; if (pc_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", pc_valid); else passed++;
    total++; if (pend !== 1'b0 || redirect_taken !== 1'b0 || taken_src !== 2'd0)
      $display("[TB] FAIL reset_flags: got pend=%b taken=%b src=%0d expected 0/0/0", pend, redirect_taken, taken_src); else passed++;
    rst = 0;
    tick();
    total++; if (pc !== 8'h10 || pc_valid !== 1'b1)
      $display("[TB] FAIL boot_fetch: got pc=%h valid=%b expected pc=10 valid=1", pc, pc_valid); else passed++;
    tick();
    total++; if (pc !== 8'h11) $display("[TB] FAIL idle_inc1: got %h expected %h", pc, 8'h11); else passed++;
    tick();
    total++; if (pc !== 8'h12) $display("[TB] FAIL idle_inc2: got %h expected %h", pc, 8'h12); else passed++;
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc;
    redirect_req = 4'b0001; redirect_tgt[7:0] = 8'hFC;
    tick();
    total++; if (pc !== 8'hFC || redirect_taken !== 1'b1 || taken_src !== 2'd0)
      $display("[TB] FAIL wrap_load: got pc=%h taken=%b src=%0d expected FC/1/0", pc, redirect_taken, taken_src); else passed++;
    redirect_req = '0;
    exp_pc = 8'hFC;
    for (int k = 0; k < 5; k++) begin
      tick();
      exp_pc = exp_pc + 8'd1;
      total++; if (pc !== exp_pc || redirect_taken !== 1'b0)
        $display("[TB] FAIL wrap_step%0d: got pc=%h taken=%b expected %h/0", k, pc, redirect_taken, exp_pc); else passed++;
    end
  endtask

  task automatic test_priority();
    redirect_req = 4'b0110; redirect_tgt[15:8] = 8'h40; redirect_tgt[23:16] = 8'h80;
    tick();
    total++; if (pc !== 8'h40 || taken_src !== 2'd1 || redirect_taken !== 1'b1)
      $display("[TB] FAIL priority: got pc=%h src=%0d taken=%b expected 40/1/1", pc, taken_src, redirect_taken); else passed++;
    redirect_req = '0;
    tick();
    total++; if (pc !== 8'h41 || redirect_taken !== 1'b0 || taken_src !== 2'd1)
      $display("[TB] FAIL priority_pulse: got pc=%h taken=%b src=%0d expected 41/0/1", pc, redirect_taken, taken_src); else passed++;
  endtask

  task automatic test_stall_pending();
    logic [7:0] held;
    held = pc;
    stall = 1;
    redirect_req = 4'b0100; redirect_tgt[23:16] = 8'h80;
    tick();
    total++; if (pc !== held || pend !== 1'b1)
      $display("[TB] FAIL stall_c1: got pc=%h pend=%b expected %h/1", pc, pend, held); else passed++;
    redirect_req = 4'b0010; redirect_tgt[15:8] = 8'h40;
    tick();
    redirect_req = 4'b1000; redirect_tgt[31:24] = 8'hC0;
    tick();
    total++; if (pc !== held || pend !== 1'b1 || redirect_taken !== 1'b0)
      $display("[TB] FAIL stall_c3: got pc=%h pend=%b taken=%b expected %h/1/0", pc, pend, redirect_taken, held); else passed++;
    stall = 0; redirect_req = '0;
    tick();
    total++; if (pc !== 8'h40 || taken_src !== 2'd1 || pend !== 1'b0 || redirect_taken !== 1'b1)
      $display("[TB] FAIL stall_release: got pc=%h src=%0d pend=%b taken=%b expected 40/1/0/1", pc, taken_src, pend, redirect_taken); else passed++;
    tick();
  endtask

  task automatic test_release_collision();
    stall = 1; redirect_req = 4'b0100; redirect_tgt[23:16] = 8'h80;
    tick();
    stall = 0; redirect_req = 4'b0001; redirect_tgt[7:0] = 8'h20;
    tick();
    total++; if (pc !== 8'h20 || taken_src !== 2'd0 || pend !== 1'b0)
      $display("[TB] FAIL collision: got pc=%h src=%0d pend=%b expected 20/0/0", pc, taken_src, pend); else passed++;
    redirect_req = '0;
    tick();
    total++; if (pc !== 8'h21 || redirect_taken !== 1'b0 || pend !== 1'b0)
      $display("[TB] FAIL collision_discard: got pc=%h taken=%b pend=%b expected 21/0/0", pc, redirect_taken, pend); else passed++;
  endtask

  task automatic test_reset_mid_pend();
    stall = 1; redirect_req = 4'b0010; redirect_tgt[15:8] = 8'h40;
    tick();
    total++; if (pend !== 1'b1) $display("[TB] FAIL midpend_setup: got pend=%b expected 1", pend); else passed++;
    rst = 1; stall = 0; redirect_req = '0;
    tick();
    total++; if (pend !== 1'b0 || pc !== RST_PC || pc_valid !== 1'b0)
      $display("[TB] FAIL midpend_reset: got pend=%b pc=%h valid=%b expected 0/10/0", pend, pc, pc_valid); else passed++;
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (pc !== RST_PC + 8'(k) || redirect_taken !== 1'b0)
        $display("[TB] FAIL midpend_after%0d: got pc=%h taken=%b expected %h/0", k, pc, redirect_taken, RST_PC + 8'(k)); else passed++;
    end
  endtask

  task automatic test_misalign();
    redirect_req = 4'b0001; redirect_tgt[7:0] = 8'h43;
    tick();
`ifdef PC_MISALIGN_CHK_EN
    total++; if (pc !== 8'h40 || misalign !== 1'b1)
      $display("[TB] FAIL misalign_load: got pc=%h mis=%b expected 40/1", pc, misalign); else passed++;
    redirect_req = '0;
    tick();
    total++; if (misalign !== 1'b0) $display("[TB] FAIL misalign_pulse: got %b expected 0", misalign); else passed++;
`else
    total++; if (pc !== 8'h43) $display("[TB] FAIL verbatim_load: got %h expected 43", pc); else passed++;
    redirect_req = '0;
    tick();
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 59) == 0);
      stall = ($urandom_range(0, 9) < 4);
      redirect_req = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      redirect_tgt = 32'($urandom);
      tick();
      total++; if (pc !== m_pc || pc_valid !== m_valid || redirect_taken !== m_taken ||
                   taken_src !== 2'(m_src) || pend !== m_pend)
        $display("[TB] FAIL random%0d: got pc=%h v=%b t=%b s=%0d p=%b expected pc=%h v=%b t=%b s=%0d p=%b",
                 n, pc, pc_valid, redirect_taken, taken_src, pend, m_pc, m_valid, m_taken, m_src, m_pend);
      else passed++;
`ifdef PC_MISALIGN_CHK_EN
      total++; if (misalign !== m_mis)
        $display("[TB] FAIL random_mis%0d: got %b expected %b", n, misalign, m_mis); else passed++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_priority();
    test_stall_pending();
    test_release_collision();
    test_reset_mid_pend();
    test_misalign();
    test_random();
    idle_inputs();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Parametrised successor to the registered 2:1 next-PC mux.
- Holds the program counter and advances it by a fixed increment each cycle.
- Selects among NUM_SRC prioritised redirect targets: branch, jump, exception, etc.
- Honours a stall input; a redirect that arrives during a stall is latched and applied when the stall releases, never lost.
- Feeds the instruction-memory address path.

Parameters:
- PC_W, 8, PC width in bits.
- NUM_SRC, 4, number of redirect sources; index 0 has highest priority.
- INC, 1, sequential increment added to the PC.
- RESET_PC, 0, PC value loaded on reset.
- ALIGN_BITS, 0, number of low target bits that must be zero; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  freeze the PC this cycle.
- redirect_req  in  NUM_SRC  per-source redirect request.
- redirect_tgt  in  NUM_SRC*PC_W  flattened targets; source i occupies bits [i*PC_W +: PC_W].
- pc  out  PC_W  current PC, registered.
- pc_valid  out  1  PC is a valid fetch address.
- redirect_taken  out  1  single-cycle pulse: pc was loaded from a redirect on the last edge.
- taken_src  out  $clog2(NUM_SRC)  source index of the last redirect taken; holds its value between redirects.
- pend  out  1  a redirect is latched, waiting for the stall to release.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - pc=RESET_PC, pc_valid=0, redirect_taken=0, taken_src=0, pend=0, state=BOOT.
  - The pending register is discarded, including when reset arrives mid-PEND.
- All outputs are registered. A request sampled at edge N is visible on pc after edge N (1-cycle latency).
- Winner = lowest index i with redirect_req[i]=1. "Any" = OR of redirect_req.
- BOOT:
  - Next edge -> RUN, pc_valid=1, pc stays RESET_PC, so RESET_PC is fetched first.
  - Requests and stall are ignored in BOOT.
- RUN, stall=0:
  - any=1: pc<=tgt[winner], redirect_taken<=1, taken_src<=winner.
  - any=0: pc<=pc+INC, truncated to PC_W (wraps modulo 2^PC_W), redirect_taken<=0.
- RUN, stall=1:
  - pc held, redirect_taken<=0.
  - any=1: pend_tgt<=tgt[winner], pend_src<=winner, pend<=1 -> PEND.
- PEND, stall=1:
  - pc held.
  - A live winner with index <= pend_src overwrites pend_tgt/pend_src; on equal index the newer target wins.
  - Lower-priority requests are ignored.
- PEND, stall=0:
  - If a live winner has index < pend_src, it is used; otherwise pend_tgt is used.
  - pc<=chosen target, redirect_taken<=1, taken_src<=chosen index, pend<=0 -> RUN.
- Stall release and a new request in the same cycle follow the rules above. Pending and live requests are never both applied.
- pc_valid stays 1 after BOOT. Stall does not drop it.

Optional Feature:
- Macro: PC_MISALIGN_CHK_EN.
- Defined:
  - Adds output port misalign (1 bit).
  - When a redirect target is applied, its low ALIGN_BITS are forced to 0 in pc.
  - misalign pulses with redirect_taken if any of those bits were 1.
  - misalign resets to 0.
- Undefined:
  - Port absent; targets loaded verbatim; ALIGN_BITS ignored.
  - ALIGN_BITS=0 with the macro defined means misalign is never asserted.

Decomposition:
- Package pc_unit_pkg holds:
  - state enum {BOOT, RUN, PEND}, 2 bits.
  - Default constants for PC_W, RESET_PC and INC.
  - A function returning the source-index width.
- Sub-module prio_enc: NUM_SRC request vector -> {any, index}, lowest index wins. It is purely combinational and reused for the live-request arbitration.

Test Plan:
- Reset then idle (PC_W=8, RESET_PC=0x10, INC=1):
  - After rst release: pc=0x10, pc_valid=0 for 1 cycle, then 1.
  - pc=0x11, 0x12 on the following cycles.
- Wrap-around: run from pc=0xFE with no requests -> 0xFF, 0x00, 0x01; no redirect_taken.
- Priority: req=4'b0110 with tgt1=0x40, tgt2=0x80 in RUN -> next pc=0x40, taken_src=1, redirect_taken high for exactly 1 cycle.
- Stall with pending redirect:
  - stall=1 for 3 cycles; req[2] (0x80) on cycle 1; req[1] (0x40) on cycle 2; req[3] (0xC0) on cycle 3.
  - Expected: pc held, pend=1 from cycle 2.
  - On release: pc=0x40, taken_src=1, pend=0.
- Release collision:
  - pend_src=2 (0x80); stall drops while req[0] (0x20) is live -> pc=0x20, taken_src=0.
  - Pending entry is discarded.
- Reset mid-PEND: rst asserted while pend=1 -> pend=0, pc=RESET_PC, state=BOOT; the old target never appears on pc.
- With PC_MISALIGN_CHK_EN, ALIGN_BITS=2: redirect to 0x43 -> pc=0x40, misalign=1 for 1 cycle.
